// File: rtl/proc_result_checker_if.sv
// Control, expected-table load, snooped write-back and result signals of proc_result_checker.
interface proc_result_checker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
);
   logic                  start;
   logic                  exp_we;
   logic [ADDR_WIDTH-1:0] exp_addr;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [CNT_WIDTH-1:0]  cycle_count;
   logic [CNT_WIDTH-1:0]  error_count;
   logic                  mism_valid;
   logic [ADDR_WIDTH-1:0] mism_addr;
   logic [DATA_WIDTH-1:0] mism_expected;
   logic [DATA_WIDTH-1:0] mism_actual;

   modport master (
      output start, exp_we, exp_addr, exp_data, wb_en, wb_addr, wb_data,
      input  busy, done, pass, cycle_count, error_count,
             mism_valid, mism_addr, mism_expected, mism_actual
   );

   modport slave (
      input  start, exp_we, exp_addr, exp_data, wb_en, wb_addr, wb_data,
      output busy, done, pass, cycle_count, error_count,
             mism_valid, mism_addr, mism_expected, mism_actual
   );
endinterface

// File: rtl/proc_result_checker.sv
// Snoops a register-file write port into a shadow copy for a fixed run length,
// then sweeps every register against a loaded expected table.
module proc_result_checker #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int CYCLE_LIMIT = 1000,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   proc_result_checker_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for start; expected table loadable
   // RUN   | shadowing write-backs for CYCLE_LIMIT cycles
   // SWEEP | comparing one register per cycle against the table
   // DONE  | results held; table loadable, start re-arms
   typedef enum logic [1:0] {IDLE, RUN, SWEEP, DONE} state_t;

   localparam int                    DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   NREGS      = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [CNT_WIDTH-1:0]  LAST_CYCLE = CNT_WIDTH'(CYCLE_LIMIT - 1);

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] shadow  [DEPTH];
   logic [DATA_WIDTH-1:0] exp_tab [DEPTH];
   logic [DEPTH-1:0]      care;
   logic [ADDR_WIDTH-1:0] idx;
   logic [CNT_WIDTH-1:0]  cycle_count;
   logic [CNT_WIDTH-1:0]  error_count;
   logic                  mism_valid;
   logic [ADDR_WIDTH-1:0] mism_addr;
   logic [DATA_WIDTH-1:0] mism_expected;
   logic [DATA_WIDTH-1:0] mism_actual;
   logic                  armed;
   logic                  exp_ok;
   logic                  wb_ok;
   logic                  miss;

   always_comb begin
      armed  = (state == IDLE) || (state == DONE);
      exp_ok = armed && bus.exp_we && ({1'b0, bus.exp_addr} < NREGS);
      // register 0 is hard-wired zero in the processor, so its writes never land
      wb_ok  = (state == RUN) && bus.wb_en && (bus.wb_addr != '0) &&
               ({1'b0, bus.wb_addr} < NREGS);
      miss   = (state == SWEEP) && care[idx] && (shadow[idx] != exp_tab[idx]);

      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = RUN;
         RUN:     if (cycle_count == LAST_CYCLE) next_state = SWEEP;
         SWEEP:   if (idx == LAST_IDX) next_state = DONE;
         DONE:    if (bus.start) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow[i]  <= '0;
            exp_tab[i] <= '0;
         end
         care          <= '0;
         idx           <= '0;
         cycle_count   <= '0;
         error_count   <= '0;
         mism_valid    <= 1'b0;
         mism_addr     <= '0;
         mism_expected <= '0;
         mism_actual   <= '0;
      end else begin
         if (exp_ok) begin
            exp_tab[bus.exp_addr] <= bus.exp_data;
            care[bus.exp_addr]    <= 1'b1;
         end
         if (armed && bus.start) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
            cycle_count <= '0;
            error_count <= '0;
         end
         if (state == RUN) begin
            cycle_count <= cycle_count + 1'b1;
            idx         <= '0;
         end
         if (wb_ok) shadow[bus.wb_addr] <= bus.wb_data;
         if (state == SWEEP) idx <= idx + 1'b1;

         mism_valid <= miss;
         if (miss) begin
            mism_addr     <= idx;
            mism_expected <= exp_tab[idx];
            mism_actual   <= shadow[idx];
            if (error_count != '1) error_count <= error_count + 1'b1;
         end
      end
   end

   assign bus.busy          = (state == RUN) || (state == SWEEP);
   assign bus.done          = (state == DONE);
   assign bus.pass          = (state == DONE) && (error_count == '0);
   assign bus.cycle_count   = cycle_count;
   assign bus.error_count   = error_count;
   assign bus.mism_valid    = mism_valid;
   assign bus.mism_addr     = mism_addr;
   assign bus.mism_expected = mism_expected;
   assign bus.mism_actual   = mism_actual;
endmodule

// File: tb/tb_proc_result_checker.sv
// Bench for proc_result_checker: cycle-level model for the main instance plus
// literal expectations, and a narrow-counter instance for saturation.
module tb_proc_result_checker;
   localparam int DW = 32, NR = 32, AW = 5, CL = 8, CW = 16;
   localparam int NRB = 8, CLB = 3, CWB = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;

   proc_result_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW))  ifa ();
   proc_result_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CWB)) ifb ();

   proc_result_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                         .CYCLE_LIMIT(CL), .CNT_WIDTH(CW))
      dut_a (.clock(clock), .reset(reset), .bus(ifa));
   proc_result_checker #(.DATA_WIDTH(DW), .NUM_REGS(NRB), .ADDR_WIDTH(AW),
                         .CYCLE_LIMIT(CLB), .CNT_WIDTH(CWB))
      dut_b (.clock(clock), .reset(reset), .bus(ifb));

   initial forever #5 clock = ~clock;

   int vectors = 0, miscompares = 0;
   int tcount = 0, t_start = 0, pulses_a = 0, pulses_b = 0, pa0 = 0, pb0 = 0;
   bit chk_en = 0;

   // model of instance A: exp/care/shadow tables and edge count since start
   logic [DW-1:0] m_exp [NR];
   logic [DW-1:0] m_shadow [NR];
   bit            m_care [NR];
   bit            m_run = 0, m_fin = 0;
   int            m_k = 0, e_cc = 0, e_ec = 0, e_ma = 0;
   bit            e_mv = 0;
   logic [DW-1:0] e_me = '0, e_mact = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic model_edge();
      bit was_busy;
      int i;
      if (reset) begin
         for (int j = 0; j < NR; j++) begin
            m_exp[j] = '0; m_shadow[j] = '0; m_care[j] = 0;
         end
         m_run = 0; m_fin = 0; m_k = 0; e_cc = 0; e_ec = 0;
         e_mv = 0; e_ma = 0; e_me = '0; e_mact = '0;
      end else begin
         was_busy = m_run;
         e_mv = 0;
         if (!was_busy) begin
            if (ifa.exp_we && int'(ifa.exp_addr) < NR) begin
               m_exp[int'(ifa.exp_addr)]  = ifa.exp_data;
               m_care[int'(ifa.exp_addr)] = 1;
            end
            if (ifa.start) begin
               for (int j = 0; j < NR; j++) m_shadow[j] = '0;
               e_cc = 0; e_ec = 0; m_run = 1; m_fin = 0; m_k = 0;
            end
         end else begin
            m_k++;
            if (m_k <= CL) begin
               e_cc = m_k;
               if (ifa.wb_en && ifa.wb_addr != 0 && int'(ifa.wb_addr) < NR)
                  m_shadow[int'(ifa.wb_addr)] = ifa.wb_data;
            end else begin
               i = m_k - CL - 1;
               if (m_care[i] && m_shadow[i] != m_exp[i]) begin
                  e_mv = 1; e_ma = i; e_me = m_exp[i]; e_mact = m_shadow[i];
                  if (e_ec < (1 << CW) - 1) e_ec++;
               end
               if (m_k == CL + NR) begin
                  m_run = 0; m_fin = 1;
               end
            end
         end
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy",          64'(ifa.busy),          64'(m_run));
         chk("done",          64'(ifa.done),          64'(m_fin));
         chk("pass",          64'(ifa.pass),          64'(m_fin && e_ec == 0));
         chk("cycle_count",   64'(ifa.cycle_count),   64'(e_cc));
         chk("error_count",   64'(ifa.error_count),   64'(e_ec));
         chk("mism_valid",    64'(ifa.mism_valid),    64'(e_mv));
         chk("mism_addr",     64'(ifa.mism_addr),     64'(e_ma));
         chk("mism_expected", 64'(ifa.mism_expected), 64'(e_me));
         chk("mism_actual",   64'(ifa.mism_actual),   64'(e_mact));
      end
      if (ifa.mism_valid === 1'b1) pulses_a++;
      if (ifb.mism_valid === 1'b1) pulses_b++;
   end

   task automatic tick();
      @(posedge clock);
      model_edge();
      tcount++;
      #1;
      reset = 0;
      ifa.start = 0; ifa.exp_we = 0; ifa.wb_en = 0;
      ifb.start = 0; ifb.exp_we = 0;
   endtask

   task automatic load(input int a, input logic [DW-1:0] d);
      ifa.exp_we = 1; ifa.exp_addr = AW'(a); ifa.exp_data = d;
      tick();
   endtask

   task automatic go();
      ifa.start = 1;
      tick();
      t_start = tcount; pa0 = pulses_a;
   endtask

   task automatic wb(input int a, input logic [DW-1:0] d);
      ifa.wb_en = 1; ifa.wb_addr = AW'(a); ifa.wb_data = d;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_done(input bit sel_b, output int n);
      bit got;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         tick();
         if ((sel_b ? ifb.done : ifa.done) === 1'b1) got = 1;
      end
      n = tcount - t_start;
      if (!got) begin
         miscompares++;
         $display("FAIL wait_done: done never rose within 300 cycles");
      end
   endtask

   int n;

   initial begin
      ifa.start = 0; ifa.exp_we = 0; ifa.exp_addr = '0; ifa.exp_data = '0;
      ifa.wb_en = 0; ifa.wb_addr = '0; ifa.wb_data = '0;
      ifb.start = 0; ifb.exp_we = 0; ifb.exp_addr = '0; ifb.exp_data = '0;
      ifb.wb_en = 0; ifb.wb_addr = '0; ifb.wb_data = '0;

      reset = 1; tick();
      chk_en = 1;
      reset = 1; tick();
      chk("rst_busy", 64'(ifa.busy), 0);
      chk("rst_done", 64'(ifa.done), 0);
      chk("rst_pass", 64'(ifa.pass), 0);
      chk("rst_err",  64'(ifa.error_count), 0);

      // matching run
      load(1, 32'd5); load(2, 32'd7);
      go(); wb(1, 32'd5); wb(2, 32'd7);
      wait_done(0, n);
      chk("t1_latency", 64'(n), 40);
      chk("t1_err",     64'(ifa.error_count), 0);
      chk("t1_pass",    64'(ifa.pass), 1);
      chk("t1_pulses",  64'(pulses_a - pa0), 0);

      // r2 mismatches; load and start during RUN are ignored
      go(); wb(1, 32'd5); wb(2, 32'd9);
      load(5, 32'hAA);
      ifa.start = 1; tick();
      wait_done(0, n);
      chk("t2_pulses", 64'(pulses_a - pa0), 1);
      chk("t2_addr",   64'(ifa.mism_addr), 2);
      chk("t2_exp",    64'(ifa.mism_expected), 7);
      chk("t2_act",    64'(ifa.mism_actual), 9);
      chk("t2_err",    64'(ifa.error_count), 1);
      chk("t2_pass",   64'(ifa.pass), 0);

      // writes to r0 dropped; write during SWEEP ignored
      load(0, 32'd0); load(3, 32'd0);
      go(); wb(0, 32'hFFFF_FFFF); wb(1, 32'd5); wb(2, 32'd7);
      idle(5); wb(3, 32'h1234);
      wait_done(0, n);
      chk("t3_latency", 64'(n), 40);
      chk("t3_pass",    64'(ifa.pass), 1);
      chk("t3_pulses",  64'(pulses_a - pa0), 0);

      // write on last RUN edge captured, one edge later ignored
      load(4, 32'h44);
      go(); wb(1, 32'd5); wb(2, 32'd7); idle(5); wb(4, 32'h44);
      wait_done(0, n);
      chk("t4a_pass",   64'(ifa.pass), 1);
      chk("t4a_pulses", 64'(pulses_a - pa0), 0);
      go(); wb(1, 32'd5); wb(2, 32'd7); idle(6); wb(4, 32'h44);
      wait_done(0, n);
      chk("t4b_pulses", 64'(pulses_a - pa0), 1);
      chk("t4b_addr",   64'(ifa.mism_addr), 4);
      chk("t4b_exp",    64'(ifa.mism_expected), 32'h44);
      chk("t4b_act",    64'(ifa.mism_actual), 0);
      chk("t4b_err",    64'(ifa.error_count), 1);

      // reset mid-SWEEP clears care bits
      go(); wb(1, 32'd5); wb(2, 32'd7); idle(10);
      chk("t5_busy_before", 64'(ifa.busy), 1);
      reset = 1; tick();
      chk("t5_busy", 64'(ifa.busy), 0);
      chk("t5_done", 64'(ifa.done), 0);
      chk("t5_err",  64'(ifa.error_count), 0);
      go();
      wait_done(0, n);
      chk("t5_latency", 64'(n), 40);
      chk("t5_pass",    64'(ifa.pass), 1);
      chk("t5_pulses",  64'(pulses_a - pa0), 0);

      // 2-bit error counter saturates at 3 across 5 failing registers
      for (int a = 1; a <= 5; a++) begin
         ifb.exp_we = 1; ifb.exp_addr = AW'(a); ifb.exp_data = 32'h10 + a;
         tick();
      end
      ifb.start = 1; tick();
      t_start = tcount; pb0 = pulses_b;
      wait_done(1, n);
      chk("sat_latency", 64'(n), 11);
      chk("sat_pulses",  64'(pulses_b - pb0), 5);
      chk("sat_err",     64'(ifb.error_count), 3);
      chk("sat_pass",    64'(ifb.pass), 0);
      chk("sat_addr",    64'(ifb.mism_addr), 5);
      chk("sat_exp",     64'(ifb.mism_expected), 32'h15);
      chk("sat_act",     64'(ifb.mism_actual), 0);
      idle(2);
      chk("sat_valid_low", 64'(ifb.mism_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
